reg_pipe_stage: RTL
===================

// Module: reg_pipe_stage
// PURPOSE
//   Generic pipeline stage register with valid/ready handshake, flush and bubble insertion.
//   Successor to the fixed IF/ID latch; used between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   The payload is an opaque WIDTH-bit bus; the stage carries no knowledge of pc/inst fields.
//   Flushed or empty slots present the BUBBLE value, e.g. a NOP encoding, to the downstream stage.
// PARAMETERS
//   WIDTH   32  payload width in bits, >=1
//   BUBBLE  0   WIDTH-bit value driven on out_data when the stage holds no valid beat
//   CNT_W   16  width of the stall performance counter, >=1
// PORTS
//   clk        in   1        clock, all state updates on posedge
//   rst        in   1        reset, synchronous, active-high
//   flush      in   1        discard all held beats (branch mispredict / exception)
//   in_valid   in   1        upstream beat present
//   in_ready   out  1        stage can accept a beat this cycle
//   in_data    in   WIDTH    upstream payload
//   out_valid  out  1        downstream beat present
//   out_ready  in   1        downstream accepts the beat this cycle (0 = stall)
//   out_data   out  WIDTH    downstream payload; BUBBLE when out_valid=0
//   stall_cnt  out  CNT_W    saturating count of cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//   - Transfer: in side when in_valid & in_ready; out side when out_valid & out_ready.
//   - Reset, all synchronous: out_valid=0, out_data=BUBBLE, stall_cnt=0, skid empty; in_ready=1 in the cycle after rst.
//   - rst has priority over flush; flush has priority over any transfer.
//   - flush cycle: next cycle out_valid=0, out_data=BUBBLE, skid empty.
//     A beat handshaken on the input in the flush cycle is dropped; in_ready is not gated by flush.
//   - Latency: an accepted beat appears on out_* exactly 1 cycle later when the stage was empty or draining.
//   - Beats leave in acceptance order; none are duplicated or lost except through flush.
//   - out_data is always registered; no combinational path from in_data to out_data.
//   - stall_cnt increments when out_valid & ~out_ready and holds at 2^CNT_W-1.
//     Only rst clears it; flush does not.
//   - in_valid with in_ready=0: the beat is not taken, and upstream must hold it.
// CONFIGURATION
//   REG_PIPE_SKID_EN undefined (default, pass-through ready):
//     - in_ready = out_ready | ~out_valid (combinational from out_ready).
//     - When in_ready=1: out_valid <= in_valid; out_data <= in_valid ? in_data : BUBBLE.
//     - When in_ready=0: out_valid and out_data hold.
//     - Full throughput at 1 entry of storage.
//   REG_PIPE_SKID_EN defined (2-entry skid buffer, ready fully registered):
//     - in_ready = ~skid_valid, driven from a flop; no comb path from out_ready.
//     - States: EMPTY (out_valid=0), BUSY (out_valid=1, skid empty), FULL (out_valid=1, skid valid).
//     - EMPTY --in xfer--> BUSY.
//     - BUSY: in xfer & out xfer -> BUSY with new data; in only -> FULL, beat to skid;
//       out only -> EMPTY; neither -> hold.
//     - FULL: in_ready=0; out xfer -> BUSY with out_data <= skid; otherwise hold.
//     - Full throughput when out_ready=1 every cycle.
//     - flush from any state -> EMPTY.
// TESTING
//   1. rst=1 2 cycles -> out_valid=0, out_data=BUBBLE, stall_cnt=0, in_ready=1.
//   2. Stream 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, 1 cycle after each input.
//   3. out_valid=1 (0x11), out_ready=0 for 5 cycles, in_valid=1 with 0x22 ->
//      0x11 held, stall_cnt=5, 0x22 delivered next after release.
//      With SKID_EN: in_ready drops 1 cycle after 0x22 is taken.
//   4. flush with in_valid=1 (0x44) and FULL/BUSY -> next cycle out_valid=0, out_data=BUBBLE; 0x44 never appears.
//   5. CNT_W=2, stall 6 cycles -> stall_cnt saturates at 3.
//      rst mid-stream -> all outputs return to reset values the next cycle.
//   6. Random valid/ready, 10k cycles, both configs -> scoreboard order-exact and lossless;
//      in_ready never depends on out_ready in the same cycle when SKID_EN is defined.

Source files
------------

// File: rtl/reg_pipe_stage.sv
// Generic pipeline stage register with valid/ready handshake, flush, bubble insertion and a
// saturating stall counter. Define REG_PIPE_SKID_EN for the 2-entry skid buffer with registered in_ready.
module reg_pipe_stage #(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter int               CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

`ifdef REG_PIPE_SKID_EN
   // state    | meaning
   // ST_EMPTY | no beat held, out_valid=0, in_ready=1
   // ST_BUSY  | one beat on out_*, skid empty, in_ready=1
   // ST_FULL  | one beat on out_*, one in skid, in_ready=0
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e           state_q;
   logic             in_ready_q;
   logic [WIDTH-1:0] skid_q;

   // In EMPTY and BUSY in_ready_q is 1, so in_valid alone marks an input transfer there.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         out_data_q  <= BUBBLE;
         skid_q      <= BUBBLE;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_valid) begin
                  state_q     <= ST_BUSY;
                  out_valid_q <= 1'b1;
                  out_data_q  <= in_data;
               end
            end
            ST_BUSY: begin
               case ({in_valid, out_ready})
                  2'b11: out_data_q <= in_data;
                  2'b10: begin
                     state_q    <= ST_FULL;
                     skid_q     <= in_data;
                     in_ready_q <= 1'b0;
                  end
                  2'b01: begin
                     state_q     <= ST_EMPTY;
                     out_valid_q <= 1'b0;
                     out_data_q  <= BUBBLE;
                  end
                  default: ;
               endcase
            end
            ST_FULL: begin
               if (out_ready) begin
                  state_q    <= ST_BUSY;
                  out_data_q <= skid_q;
                  skid_q     <= BUBBLE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               out_valid_q <= 1'b0;
               out_data_q  <= BUBBLE;
               skid_q      <= BUBBLE;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
`else
   logic             out_valid_d;
   logic [WIDTH-1:0] out_data_d;

   assign in_ready = out_ready | ~out_valid_q;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (flush) begin
         out_valid_d = 1'b0;
         out_data_d  = BUBBLE;
      end else if (in_ready) begin
         out_valid_d = in_valid;
         out_data_d  = in_valid ? in_data : BUBBLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= BUBBLE;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
`endif

   // Counts stalled cycles independently of flush; only rst clears it.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign stall_cnt = stall_cnt_q;

endmodule
